// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the serial ALU and its digit slice.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-wide ALU slice: ripple add over the digit plus bitwise logic ops.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic [2:0]       op,
  input  logic             ci,
  output logic [DIGIT-1:0] r,
  output logic             co,
  output logic             c_top
);

  logic c_rip;

  always_comb begin
    r     = '0;
    co    = 1'b0;
    c_top = ci;
    c_rip = ci;
    case (op)
      // SUB arrives with y already inverted and ci=1, so it shares the adder
      OP_ADD, OP_SUB: begin
        for (int i = 0; i < DIGIT; i++) begin
          if (i == DIGIT - 1) c_top = c_rip;
          r[i]  = x[i] ^ y[i] ^ c_rip;
          c_rip = (x[i] & y[i]) | (x[i] & c_rip) | (y[i] & c_rip);
        end
        co = c_rip;
      end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_PASS: r = x;
      OP_NOT:  r = ~x;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial_n.sv
// Digit-serial ALU: WIDTH-bit operands processed DIGIT bits per clock, valid/ready on both sides.
//   state  | meaning
//   S_IDLE | in_ready high, waiting for an operand/opcode
//   S_BUSY | shifting digits through the slice, cnt counts digits done
//   S_DONE | out_valid high, result held until out_ready
module alu_serial_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_param
    $error("alu_serial_n: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] x_q, y_q, res_q;
  logic             chain_q;
  logic [2:0]       op_q;

  logic [DIGIT-1:0] d_r;
  logic             d_co, d_ctop;
  logic             last, is_arith;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_shift;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (x_q[DIGIT-1:0]),
    .y     (y_q[DIGIT-1:0]),
    .op    (op_q),
    .ci    (chain_q),
    .r     (d_r),
    .co    (d_co),
    .c_top (d_ctop)
  );

  assign last      = (cnt_q == CNT_W'(N - 1));
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign res_cat   = {d_r, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      chain_q  <= 1'b0;
      op_q     <= OP_ADD;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q   <= in_x;
            op_q  <= sel;
            cnt_q <= '0;
            res_q <= '0;
            if (sel == OP_SUB) begin
              y_q     <= ~in_y;
              chain_q <= 1'b1;
            end else begin
              y_q     <= in_y;
              chain_q <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          x_q     <= x_q >> DIGIT;
          y_q     <= y_q >> DIGIT;
          res_q   <= res_shift;
          chain_q <= d_co;
          cnt_q   <= cnt_q + 1'b1;
          // Flags come from the final digit; carry into the MSB is the slice's c_top
          if (last) begin
            sum      <= res_shift;
            carry    <= is_arith & d_co;
            overflow <= is_arith & (d_ctop ^ d_co);
            zero     <= (res_shift == '0);
            negative <= res_shift[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_n.sv
// Directed bench for alu_serial_n in W8/D1, W8/D4 and W16/D4 configurations.
module tb_alu_serial_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  vld = '0;
  logic [15:0] x_b = '0, y_b = '0;
  logic [2:0]  sel_b = '0;
  logic        out_ready = 1'b0;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [7:0]  sum0, sum1;
  logic [15:0] sum2;
  logic [3:0]  fl0, fl1, fl2;

  int total = 0;
  int bad = 0;
  int cur = 0;

  logic [15:0] o_sum;
  logic [3:0]  o_flags;
  logic        o_valid, o_rdy;

  always #5 clk = ~clk;

  alu_serial_n #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy0),
    .in_x(x_b[7:0]), .in_y(y_b[7:0]), .sel(sel_b), .out_valid(ov0),
    .out_ready(out_ready), .sum(sum0), .carry(fl0[3]), .overflow(fl0[2]),
    .zero(fl0[1]), .negative(fl0[0]));

  alu_serial_n #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy1),
    .in_x(x_b[7:0]), .in_y(y_b[7:0]), .sel(sel_b), .out_valid(ov1),
    .out_ready(out_ready), .sum(sum1), .carry(fl1[3]), .overflow(fl1[2]),
    .zero(fl1[1]), .negative(fl1[0]));

  alu_serial_n #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy2),
    .in_x(x_b), .in_y(y_b), .sel(sel_b), .out_valid(ov2),
    .out_ready(out_ready), .sum(sum2), .carry(fl2[3]), .overflow(fl2[2]),
    .zero(fl2[1]), .negative(fl2[0]));

  always_comb begin
    o_sum = {8'h00, sum0}; o_flags = fl0; o_valid = ov0; o_rdy = rdy0;
    case (cur)
      1: begin o_sum = {8'h00, sum1}; o_flags = fl1; o_valid = ov1; o_rdy = rdy1; end
      2: begin o_sum = sum2;          o_flags = fl2; o_valid = ov2; o_rdy = rdy2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // flags packed {carry, overflow, zero, negative}
  task automatic do_op(input int inst, input string tag, input logic [2:0] op,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp_sum, input logic [3:0] exp_fl,
                       input int exp_lat);
    int lat;
    cur = inst;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(o_rdy), 32'd1);
    vld[inst] = 1'b1; x_b = x; y_b = y; sel_b = op; out_ready = 1'b0;
    @(posedge clk); #1;
    vld[inst] = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},   32'(lat),     32'(exp_lat));
    check({tag, "_sum"},   32'(o_sum),   32'(exp_sum));
    check({tag, "_flags"}, 32'(o_flags), 32'(exp_fl));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop"}, {31'd0, o_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cur = 0;
    check("rst_sum",   32'(o_sum),   32'd0);
    check("rst_flags", 32'(o_flags), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rdy",   32'(o_rdy),   32'd1);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, "add_ff_01", 3'b000, 16'h00FF, 16'h0001, 16'h0000, 4'b1010, 8);
    do_op(0, "sub_05_07", 3'b001, 16'h0005, 16'h0007, 16'h00FE, 4'b0001, 8);
    do_op(0, "sub_80_01", 3'b001, 16'h0080, 16'h0001, 16'h007F, 4'b1100, 8);
    do_op(1, "add_7f_01", 3'b000, 16'h007F, 16'h0001, 16'h0080, 4'b0101, 2);
    do_op(1, "xor_a5_ff", 3'b100, 16'h00A5, 16'h00FF, 16'h005A, 4'b0000, 2);
    do_op(2, "nor_0_0",   3'b101, 16'h0000, 16'h0000, 16'hFFFF, 4'b0001, 4);
    do_op(2, "pass_1234", 3'b110, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000, 4);
    do_op(2, "not_ffff",  3'b111, 16'hFFFF, 16'h0F0F, 16'h0000, 4'b0010, 4);

    // backpressure: ADD 3+4 with in_valid/in_x thrashing during BUSY
    cur = 0;
    @(negedge clk);
    vld[0] = 1'b1; x_b = 16'h0003; y_b = 16'h0004; sel_b = 3'b000;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      vld[0] = ~vld[0];
      x_b = 16'($urandom);
      @(posedge clk); #1;
      if (i < 7) check("bp_busy_rdy", 32'(o_rdy), 32'd0);
    end
    vld[0] = 1'b0;
    check("bp_valid", 32'(o_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_sum",   32'(o_sum),   32'h07);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_rdy",   32'(o_rdy),   32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rdy", 32'(o_rdy), 32'd1);
    out_ready = 1'b0;

    // asynchronous reset at cnt = 3 of an ADD
    @(negedge clk);
    vld[0] = 1'b1; x_b = 16'h00FF; y_b = 16'h00FF; sel_b = 3'b000;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum",   32'(o_sum),   32'd0);
    check("mid_rst_flags", 32'(o_flags), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_rdy",   32'(o_rdy),   32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_out", 32'(o_valid), 32'd0);
    do_op(0, "add_10_20", 3'b000, 16'h0010, 16'h0020, 16'h0030, 4'b0000, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
